// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic feeder.
// Widths, feeder state encoding, address/counter sizing.
package systolic_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic int addr_w(input int k);
    return $clog2(2 * k);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/systolic_feeder_operand_buf.sv
// 2*K_DIM x DATA_W operand register file, sync clear, one write port.
// Ports: clk_i, clr_i, wr_en_i/wr_addr_i/wr_data_i, k_i -> rd0_o, rd1_o.
module operand_buf
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K_DIM  = 2,
  parameter bit IS_B   = 1'b0,
  parameter int KW     = 2,
  parameter int AW     = addr_w(K_DIM)
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [KW-1:0]     k_i,
  output logic [DATA_W-1:0] rd0_o,
  output logic [DATA_W-1:0] rd1_o
);

  localparam int N = 2 * K_DIM;
  localparam logic [AW:0] N_L = (AW+1)'(N);

  logic [DATA_W-1:0] mem_q [N];
  logic [AW-1:0]     i0;
  logic [AW-1:0]     i1;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (wr_en_i && ({1'b0, wr_addr_i} < N_L)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A is row-major (row i at i*K), B is k*2+j.
  always_comb begin
    if (IS_B) begin
      i0 = AW'(2 * int'(k_i));
      i1 = AW'(2 * int'(k_i) + 1);
    end else begin
      i0 = AW'(int'(k_i));
      i1 = AW'(K_DIM + int'(k_i));
    end
  end

  assign rd0_o = mem_q[i0];
  assign rd1_o = mem_q[i1];

endmodule

// File: rtl/systolic_feeder.sv
// Operand sequencer and result capture for a 2x2 systolic array.
// Ports: wr_* buffer load, start/busy/done, acc_clr, a*/b* out, c* in, r* out.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int K_DIM  = 2,
  parameter int PE_LAT = 1,
  parameter int AW     = addr_w(K_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              acc_clr,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] b2,
  input  logic [ACC_W-1:0]  c11,
  input  logic [ACC_W-1:0]  c12,
  input  logic [ACC_W-1:0]  c21,
  input  logic [ACC_W-1:0]  c22,
  output logic [ACC_W-1:0]  r11,
  output logic [ACC_W-1:0]  r12,
  output logic [ACC_W-1:0]  r21,
  output logic [ACC_W-1:0]  r22,
  output logic              result_valid
);

  localparam int CW = $clog2(max_int(K_DIM, PE_LAT) + 1);
  localparam logic [CW-1:0] K_LAST = CW'(K_DIM - 1);
  localparam logic [CW-1:0] D_LAST = CW'(PE_LAT - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic clr_q, clr_d;
  logic rv_q, rv_d;
  logic [DATA_W-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [DATA_W-1:0] b1_q, b1_d, b2_q, b2_d;
  logic [ACC_W-1:0] r11_q, r11_d, r12_q, r12_d;
  logic [ACC_W-1:0] r21_q, r21_d, r22_q, r22_d;

  logic idle;
  logic buf_we;
  logic [DATA_W-1:0] a_rd0, a_rd1, b_rd0, b_rd1;

  assign idle   = (state_q == S_IDLE);
  assign buf_we = wr_en & idle;

  // Read index is the next beat so operands register in step with state.
  operand_buf #(
    .DATA_W(DATA_W), .K_DIM(K_DIM),
    .IS_B(1'b0), .KW(CW), .AW(AW)
  ) u_abuf (
    .clk_i(clk), .clr_i(rst),
    .wr_en_i(buf_we & ~wr_sel),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .k_i(cnt_d), .rd0_o(a_rd0), .rd1_o(a_rd1)
  );

  operand_buf #(
    .DATA_W(DATA_W), .K_DIM(K_DIM),
    .IS_B(1'b1), .KW(CW), .AW(AW)
  ) u_bbuf (
    .clk_i(clk), .clr_i(rst),
    .wr_en_i(buf_we & wr_sel),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .k_i(cnt_d), .rd0_o(b_rd0), .rd1_o(b_rd1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      rv_q    <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      r11_q   <= '0;
      r12_q   <= '0;
      r21_q   <= '0;
      r22_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      rv_q    <= rv_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      r11_q   <= r11_d;
      r12_q   <= r12_d;
      r21_q   <= r21_d;
      r22_q   <= r22_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
        cnt_d   = '0;
      end
      S_STREAM: begin
        if (cnt_q == K_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == D_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land registered.
  always_comb begin
    logic strm;
    logic cap;
    strm   = (state_d == S_STREAM);
    cap    = (state_q == S_DRAIN) && (cnt_q == D_LAST);
    busy_d = (state_d == S_CLEAR) || strm || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    clr_d  = (state_d == S_CLEAR);
    a1_d   = strm ? a_rd0 : '0;
    a2_d   = strm ? a_rd1 : '0;
    b1_d   = strm ? b_rd0 : '0;
    b2_d   = strm ? b_rd1 : '0;
    rv_d   = rv_q;
    if (idle && start) rv_d = 1'b0;
    if (done_d) rv_d = 1'b1;
    r11_d  = cap ? c11 : r11_q;
    r12_d  = cap ? c12 : r12_q;
    r21_d  = cap ? c21 : r21_q;
    r22_d  = cap ? c22 : r22_q;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign acc_clr      = clr_q;
  assign result_valid = rv_q;
  assign a1  = a1_q;
  assign a2  = a2_q;
  assign b1  = b1_q;
  assign b2  = b2_q;
  assign r11 = r11_q;
  assign r12 = r12_q;
  assign r21 = r21_q;
  assign r22 = r22_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench: feeder plus a 2x2 broadcast-MAC array model.
// Checks timing, results, ignored starts/writes and mid-run reset.
module tb_systolic_feeder;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [1:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done, acc_clr, result_valid;
  logic [DW-1:0] a1, a2, b1, b2;
  logic [CW-1:0] c11, c12, c21, c22;
  logic [CW-1:0] r11, r12, r21, r22;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_feeder #(
    .DATA_W(DW), .ACC_W(CW), .K_DIM(2), .PE_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done),
    .acc_clr(acc_clr),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .r11(r11), .r12(r12), .r21(r21), .r22(r22),
    .result_valid(result_valid)
  );

  // Array model: one-cycle MAC per PE, cleared by rst | acc_clr.
  always_ff @(posedge clk) begin
    if (rst | acc_clr) begin
      c11 <= '0;
      c12 <= '0;
      c21 <= '0;
      c22 <= '0;
    end else begin
      c11 <= c11 + CW'(a1) * CW'(b1);
      c12 <= c12 + CW'(a1) * CW'(b2);
      c21 <= c21 + CW'(a2) * CW'(b1);
      c22 <= c22 + CW'(a2) * CW'(b2);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic sel, input logic [1:0] ad,
                    input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = ad;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [DW-1:0] a00, a01, a10, a11,
                      input logic [DW-1:0] b00, b01, b10, b11);
    wr(1'b0, 2'd0, a00);
    wr(1'b0, 2'd1, a01);
    wr(1'b0, 2'd2, a10);
    wr(1'b0, 2'd3, a11);
    wr(1'b1, 2'd0, b00);
    wr(1'b1, 2'd1, b01);
    wr(1'b1, 2'd2, b10);
    wr(1'b1, 2'd3, b11);
  endtask

  task automatic chk_r(input string tag,
                       input int e11, e12, e21, e22);
    chk({tag, ".r11"}, 32'(r11), e11);
    chk({tag, ".r12"}, 32'(r12), e12);
    chk({tag, ".r21"}, 32'(r21), e21);
    chk({tag, ".r22"}, 32'(r22), e22);
  endtask

  // Pulse start, leave at negedge of cycle 5 (done cycle).
  task automatic run5();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    @(negedge clk);
    step();
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.rv", 32'(result_valid), 0);
    chk("rst.ops", 32'({a1, a2, b1, b2}), 0);
    chk_r("rst", 0, 0, 0, 0);
    rst = 1'b0;
    step();

    load(1, 2, 3, 4, 5, 6, 7, 8);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("c1.busy", 32'(busy), 1);
    chk("c1.clr", 32'(acc_clr), 1);
    chk("c1.ops", 32'({a1, a2, b1, b2}), 0);
    step();
    chk("c2.ops", 32'({a1, a2, b1, b2}),
        32'({8'd1, 8'd3, 8'd5, 8'd6}));
    chk("c2.clr", 32'(acc_clr), 0);
    step();
    chk("c3.ops", 32'({a1, a2, b1, b2}),
        32'({8'd2, 8'd4, 8'd7, 8'd8}));
    chk("c3.done", 32'(done), 0);
    step();
    chk("c4.busy", 32'(busy), 1);
    chk("c4.ops", 32'({a1, a2, b1, b2}), 0);
    step();
    chk("c5.done", 32'(done), 1);
    chk("c5.busy", 32'(busy), 0);
    chk("c5.rv", 32'(result_valid), 1);
    chk_r("run1", 19, 22, 43, 50);
    step();
    chk("c6.done", 32'(done), 0);
    chk("c6.rv", 32'(result_valid), 1);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("rerun.rv_clr", 32'(result_valid), 0);
    repeat (4) step();
    chk("rerun.done", 32'(done), 1);
    chk_r("rerun", 19, 22, 43, 50);
    step();

    load(255, 255, 255, 255, 255, 255, 255, 255);
    run5();
    chk_r("max", 64514, 64514, 64514, 64514);
    step();

    load(1, 2, 3, 4, 5, 6, 7, 8);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign.c3busy", 32'(busy), 1);
    step();
    chk("ign.c4done", 32'(done), 0);
    step();
    chk("ign.c5done", 32'(done), 1);
    start = 1'b1;
    step();
    chk("ign.c6done", 32'(done), 0);
    chk("ign.c6busy", 32'(busy), 0);
    step();
    start = 1'b0;
    chk("acc.c7busy", 32'(busy), 1);
    chk("acc.c7clr", 32'(acc_clr), 1);
    repeat (4) step();
    chk("acc.done", 32'(done), 1);
    chk_r("acc", 19, 22, 43, 50);
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    wr(1'b0, 2'd0, 8'd9);
    step();
    step();
    chk("frz.done", 32'(done), 1);
    chk_r("frz", 19, 22, 43, 50);
    step();
    run5();
    chk_r("frz.rerun", 19, 22, 43, 50);
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid.busy", 32'(busy), 0);
    chk("mid.done", 32'(done), 0);
    chk("mid.clr", 32'(acc_clr), 0);
    chk("mid.rv", 32'(result_valid), 0);
    chk("mid.ops", 32'({a1, a2, b1, b2}), 0);
    chk_r("mid", 0, 0, 0, 0);
    step();
    chk("mid.nodone1", 32'(done), 0);
    step();
    chk("mid.nodone2", 32'(done), 0);
    run5();
    chk("zero.done", 32'(done), 1);
    chk_r("zero", 0, 0, 0, 0);
    step();

    wr(1'b1, 2'd0, 8'd1);
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_addr = 2'd0;
    wr_data = 8'd3;
    start   = 1'b1;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    repeat (4) step();
    chk("wrst.done", 32'(done), 1);
    chk_r("wrst", 3, 0, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
